// File: rtl/branch_decode_pkg.sv
// Shared constants and types for the branch format decoder.
//   Opcode/XO constants, branch kind codes, default unit IDs, the packed
//   decoded-field struct, and the offset sign-extension helper.
package branch_decode_pkg;

  localparam logic [5:0] OPC_BC = 6'd16;
  localparam logic [5:0] OPC_B  = 6'd18;
  localparam logic [5:0] OPC_XL = 6'd19;

  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;
  localparam logic [9:0] XO_BCTAR = 10'd560;

  localparam int FX_UNIT_ID     = 0;
  localparam int BRANCH_UNIT_ID = 6;

  typedef enum logic [2:0] {
    KIND_I   = 3'd0,
    KIND_B   = 3'd1,
    KIND_LR  = 3'd2,
    KIND_CTR = 3'd3,
    KIND_TAR = 3'd4
  } branch_kind_e;

  typedef struct packed {
    logic [5:0]   opcode;
    logic [4:0]   bo;
    logic [4:0]   bi;
    logic [1:0]   bh;
    logic         aa;
    logic         lk;
    branch_kind_e kind;
    logic         ctr_rd;
    logic         ctr_wr;
    logic         lr_rd;
    logic         lr_wr;
    logic         tar_rd;
    logic         illegal;
  } dec_fields_t;

  // Sign-extends a 26-bit byte offset (LI||00, or BD||00 pre-extended) to 64 bits.
  function automatic logic [63:0] sext_offset(input logic [25:0] v);
    return {{38{v[25]}}, v};
  endfunction

endpackage

// File: rtl/branch_format_decoder_if.sv
// Bus bundle of the branch format decoder.
//   Upstream side: valid_i/ready_o plus instruction word and its tags.
//   Downstream side: valid_o/ready_i plus the decoded FIFO head fields.
//   slave = decoder view, master = environment view.
interface branch_format_decoder_if #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 6,
  parameter int funcUnitCodeSize        = 3
);
  logic                               valid_i;
  logic                               ready_o;
  logic [instructionWidth-1:0]        instruction_i;
  logic [addressWidth-1:0]            instructionAddress_i;
  logic                               is64Bit_i;
  logic [PidSize-1:0]                 instructionPid_i;
  logic [TidSize-1:0]                 instructionTid_i;
  logic [instructionCounterWidth-1:0] instructionMajId_i;
  logic                               valid_o;
  logic                               ready_i;
  logic [opcodeSize-1:0]              opcode_o;
  logic [addressWidth-1:0]            address_o;
  logic [funcUnitCodeSize-1:0]        funcUnit_o;
  logic [instructionCounterWidth-1:0] majId_o;
  logic [instMinIdWidth-1:0]          minId_o;
  logic                               is64Bit_o;
  logic [PidSize-1:0]                 pid_o;
  logic [TidSize-1:0]                 tid_o;
  logic [4:0]                         bo_o;
  logic [4:0]                         bi_o;
  logic [1:0]                         bh_o;
  logic [addressWidth-1:0]            offset_o;
  logic                               aa_o;
  logic                               lk_o;
  logic [2:0]                         kind_o;
  logic                               ctrRd_o;
  logic                               ctrWr_o;
  logic                               lrRd_o;
  logic                               lrWr_o;
  logic                               tarRd_o;
  logic                               illegal_o;

  modport slave (
    input  valid_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, instructionMajId_i, ready_i,
    output ready_o, valid_o, opcode_o, address_o, funcUnit_o, majId_o, minId_o,
           is64Bit_o, pid_o, tid_o, bo_o, bi_o, bh_o, offset_o, aa_o, lk_o,
           kind_o, ctrRd_o, ctrWr_o, lrRd_o, lrWr_o, tarRd_o, illegal_o
  );

  modport master (
    output valid_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, instructionMajId_i, ready_i,
    input  ready_o, valid_o, opcode_o, address_o, funcUnit_o, majId_o, minId_o,
           is64Bit_o, pid_o, tid_o, bo_o, bi_o, bh_o, offset_o, aa_o, lk_o,
           kind_o, ctrRd_o, ctrWr_o, lrRd_o, lrWr_o, tarRd_o, illegal_o
  );
endinterface

// File: rtl/decode_out_fifo.sv
// Circular-buffer FIFO holding decoded entries.
//   clock_i/reset_i : clock, synchronous active-low reset
//   push_i/push_data_i : write request and data (ignored when full without pop)
//   pop_i           : read request (ignored when empty)
//   head_o          : oldest entry; full_o/empty_o : occupancy flags
module decode_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem [Depth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CountW-1:0] count;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count == CountW'(Depth));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem[rd_ptr];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/branch_format_decoder.sv
// Decode-2 stage for POWER branch instructions (b, bc, bclr, bcctr, bctar).
//   clock_i : clock
//   reset_i : synchronous active-low reset
//   bus     : upstream valid/ready instruction input and downstream
//             valid/ready decoded-entry output (FIFO head).
// CTR-decrement-and-link branches may be cracked into two micro-ops.
module branch_format_decoder
  import branch_decode_pkg::*;
#(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 6,
  parameter int funcUnitCodeSize        = 3,
  parameter int FXUnitId                = FX_UNIT_ID,
  parameter int BranchUnitID            = BRANCH_UNIT_ID,
  parameter int OutFifoDepth            = 4,
  parameter int SplitCtrLink            = 1,
  parameter int DecoderInstance         = 0
) (
  input logic                     clock_i,
  input logic                     reset_i,
  branch_format_decoder_if.slave  bus
);
  if (OutFifoDepth < 2 || DecoderInstance < 0) begin : g_bad_config
    $error("branch_format_decoder: OutFifoDepth must be >= 2");
  end

  typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

  typedef struct packed {
    dec_fields_t                        f;
    logic [funcUnitCodeSize-1:0]        func_unit;
    logic [instMinIdWidth-1:0]          min_id;
    logic [addressWidth-1:0]            address;
    logic [addressWidth-1:0]            offset;
    logic [instructionCounterWidth-1:0] maj_id;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
  } entry_t;

  state_e                      state, state_next;
  entry_t                      pending;
  entry_t                      dec, uop0, uop1, push_data, head_e, out_e;
  dec_fields_t                 fld;
  logic [instructionWidth-1:0] ins;
  logic [9:0]                  xo;
  logic                        ctr_dec;
  logic [63:0]                 off64;
  logic                        split;
  logic                        accept, push, pop;
  logic                        fifo_full, fifo_empty;
  logic [$bits(entry_t)-1:0]   head_bits;

  // Instruction bit k (big-endian numbering) is ins[31-k].
  assign ins     = bus.instruction_i;
  assign xo      = ins[10:1];
  assign ctr_dec = ~ins[23];

  always_comb begin
    fld        = '0;
    off64      = '0;
    fld.opcode = ins[31:26];
    fld.bo     = ins[25:21];
    fld.bi     = ins[20:16];
    fld.bh     = ins[12:11];
    fld.aa     = ins[1];
    fld.lk     = ins[0];
    fld.lr_wr  = ins[0];
    fld.kind   = KIND_I;
    case (fld.opcode)
      OPC_B: off64 = sext_offset({ins[25:2], 2'b00});
      OPC_BC: begin
        fld.kind   = KIND_B;
        off64      = sext_offset({{10{ins[15]}}, ins[15:2], 2'b00});
        fld.ctr_rd = ctr_dec;
        fld.ctr_wr = ctr_dec;
      end
      OPC_XL: begin
        fld.ctr_rd = ctr_dec;
        fld.ctr_wr = ctr_dec;
        case (xo)
          XO_BCLR: begin
            fld.kind  = KIND_LR;
            fld.lr_rd = 1'b1;
          end
          XO_BCCTR: begin
            fld.kind    = KIND_CTR;
            fld.ctr_rd  = 1'b1;
            fld.illegal = ctr_dec;
          end
          XO_BCTAR: begin
            fld.kind   = KIND_TAR;
            fld.tar_rd = 1'b1;
          end
          default: fld.illegal = 1'b1;
        endcase
      end
      default: fld.illegal = 1'b1;
    endcase
    if (fld.illegal) begin
      fld.kind   = KIND_I;
      fld.ctr_rd = 1'b0;
      fld.ctr_wr = 1'b0;
      fld.lr_rd  = 1'b0;
      fld.lr_wr  = 1'b0;
      fld.tar_rd = 1'b0;
      off64      = '0;
    end
  end

  // ctr_wr && lr_wr can only both survive for a legal CTR-decrementing link branch.
  assign split = (SplitCtrLink != 0) && fld.ctr_wr && fld.lr_wr;

  always_comb begin
    dec           = '0;
    dec.f         = fld;
    dec.func_unit = funcUnitCodeSize'(BranchUnitID);
    dec.address   = bus.instructionAddress_i;
    dec.offset    = addressWidth'(off64);
    dec.maj_id    = bus.instructionMajId_i;
    dec.is64      = bus.is64Bit_i;
    dec.pid       = bus.instructionPid_i;
    dec.tid       = bus.instructionTid_i;

    uop0           = dec;
    uop0.func_unit = funcUnitCodeSize'(FXUnitId);
    uop0.f.lr_wr   = 1'b0;
    uop0.f.lr_rd   = 1'b0;
    uop0.f.tar_rd  = 1'b0;

    uop1          = dec;
    uop1.min_id   = instMinIdWidth'(1);
    uop1.f.ctr_wr = 1'b0;
  end

  assign bus.ready_o = reset_i && (state == ST_IDLE) && !fifo_full;
  assign bus.valid_o = reset_i && !fifo_empty;
  assign accept      = bus.valid_i && bus.ready_o;
  assign pop         = bus.valid_o && bus.ready_i;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_data  = dec;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          push = 1'b1;
          if (split) begin
            push_data  = uop0;
            state_next = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        if (!fifo_full || pop) begin
          push       = 1'b1;
          push_data  = pending;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      state <= state_next;
      if (accept && split) begin
        pending <= uop1;
      end
    end
  end

  decode_out_fifo #(
    .Width($bits(entry_t)),
    .Depth(OutFifoDepth)
  ) u_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head_bits),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Stale buffer contents are hidden so data outputs read 0 whenever nothing is valid.
  assign head_e = head_bits;
  assign out_e  = bus.valid_o ? head_e : '0;

  assign bus.opcode_o   = opcodeSize'(out_e.f.opcode);
  assign bus.address_o  = out_e.address;
  assign bus.funcUnit_o = out_e.func_unit;
  assign bus.majId_o    = out_e.maj_id;
  assign bus.minId_o    = out_e.min_id;
  assign bus.is64Bit_o  = out_e.is64;
  assign bus.pid_o      = out_e.pid;
  assign bus.tid_o      = out_e.tid;
  assign bus.bo_o       = out_e.f.bo;
  assign bus.bi_o       = out_e.f.bi;
  assign bus.bh_o       = out_e.f.bh;
  assign bus.offset_o   = out_e.offset;
  assign bus.aa_o       = out_e.f.aa;
  assign bus.lk_o       = out_e.f.lk;
  assign bus.kind_o     = out_e.f.kind;
  assign bus.ctrRd_o    = out_e.f.ctr_rd;
  assign bus.ctrWr_o    = out_e.f.ctr_wr;
  assign bus.lrRd_o     = out_e.f.lr_rd;
  assign bus.lrWr_o     = out_e.f.lr_wr;
  assign bus.tarRd_o    = out_e.f.tar_rd;
  assign bus.illegal_o  = out_e.f.illegal;
endmodule

// File: tb/tb_branch_format_decoder.sv
module tb_branch_format_decoder;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  branch_format_decoder_if bus ();

  branch_format_decoder dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] addr);
    bus.valid_i              = 1'b1;
    bus.instruction_i        = ins;
    bus.instructionAddress_i = addr;
    bus.instructionMajId_i   = addr + 64'd100;
    bus.is64Bit_i            = 1'b1;
    bus.instructionPid_i     = 20'h3;
    bus.instructionTid_i     = 16'h2;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ready_i = 1'b0;
    drive(32'h0, 64'h0);
    bus.valid_i = 1'b0;
    step();
    step();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.valid_o); else passed++;
    checks++; if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", bus.ready_o); else passed++;
    checks++; if ({bus.opcode_o, bus.kind_o, bus.minId_o} !== 16'h0) $display("FAIL reset_data got=%0h exp=0", {bus.opcode_o, bus.kind_o, bus.minId_o}); else passed++;
    checks++; if (bus.offset_o !== 64'h0) $display("FAIL reset_offset got=%0h exp=0", bus.offset_o); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.ready_o !== 1'b1) $display("FAIL post_reset_ready got=%0b exp=1", bus.ready_o); else passed++;
  endtask

  task automatic test_bc();
    bus.ready_i = 1'b1;
    drive(32'h41820008, 64'h1000);
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b1) $display("FAIL bc_valid got=%0b exp=1", bus.valid_o); else passed++;
    checks++; if (bus.kind_o !== 3'd1) $display("FAIL bc_kind got=%0d exp=1", bus.kind_o); else passed++;
    checks++; if ({bus.bo_o, bus.bi_o} !== {5'd12, 5'd2}) $display("FAIL bc_bo_bi got=%0d/%0d exp=12/2", bus.bo_o, bus.bi_o); else passed++;
    checks++; if (bus.offset_o !== 64'd8) $display("FAIL bc_offset got=%0h exp=8", bus.offset_o); else passed++;
    checks++; if ({bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o} !== 5'b00000) $display("FAIL bc_flags got=%b exp=00000", {bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o}); else passed++;
    checks++; if ({bus.minId_o, bus.funcUnit_o, bus.opcode_o} !== {7'd0, 3'd6, 6'd16}) $display("FAIL bc_ids got=%0d/%0d/%0d exp=0/6/16", bus.minId_o, bus.funcUnit_o, bus.opcode_o); else passed++;
    checks++; if ({bus.address_o, bus.majId_o} !== {64'h1000, 64'h1064}) $display("FAIL bc_addr got=%0h/%0h exp=1000/1064", bus.address_o, bus.majId_o); else passed++;
    checks++; if ({bus.illegal_o, bus.is64Bit_o, bus.pid_o, bus.tid_o} !== {1'b0, 1'b1, 20'h3, 16'h2}) $display("FAIL bc_tags got=%0b/%0b/%0h/%0h exp=0/1/3/2", bus.illegal_o, bus.is64Bit_o, bus.pid_o, bus.tid_o); else passed++;
    step();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL bc_drained got=%0b exp=0", bus.valid_o); else passed++;
  endtask

  task automatic test_b();
    drive(32'h4BFFFFFC, 64'h1004);
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.kind_o !== 3'd0) $display("FAIL b_kind got=%0d exp=0", bus.kind_o); else passed++;
    checks++; if (bus.offset_o !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL b_offset got=%0h exp=fffffffffffffffc", bus.offset_o); else passed++;
    checks++; if ({bus.aa_o, bus.lk_o, bus.lrWr_o, bus.opcode_o} !== {1'b0, 1'b0, 1'b0, 6'd18}) $display("FAIL b_bits got=%0b/%0b/%0b/%0d exp=0/0/0/18", bus.aa_o, bus.lk_o, bus.lrWr_o, bus.opcode_o); else passed++;
    step();
  endtask

  task automatic test_split();
    drive(32'h42000005, 64'h2000);
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.ready_o !== 1'b0) $display("FAIL split_ready got=%0b exp=0", bus.ready_o); else passed++;
    checks++; if ({bus.valid_o, bus.minId_o, bus.funcUnit_o} !== {1'b1, 7'd0, 3'd0}) $display("FAIL uop0_ids got=%0b/%0d/%0d exp=1/0/0", bus.valid_o, bus.minId_o, bus.funcUnit_o); else passed++;
    checks++; if ({bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o} !== 5'b11000) $display("FAIL uop0_flags got=%b exp=11000", {bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o}); else passed++;
    step();
    checks++; if ({bus.valid_o, bus.minId_o, bus.funcUnit_o} !== {1'b1, 7'd1, 3'd6}) $display("FAIL uop1_ids got=%0b/%0d/%0d exp=1/1/6", bus.valid_o, bus.minId_o, bus.funcUnit_o); else passed++;
    checks++; if ({bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o} !== 5'b10010) $display("FAIL uop1_flags got=%b exp=10010", {bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o}); else passed++;
    checks++; if ({bus.offset_o, bus.kind_o, bus.address_o} !== {64'd4, 3'd1, 64'h2000}) $display("FAIL uop1_data got=%0h/%0d/%0h exp=4/1/2000", bus.offset_o, bus.kind_o, bus.address_o); else passed++;
    checks++; if (bus.ready_o !== 1'b1) $display("FAIL split_ready_back got=%0b exp=1", bus.ready_o); else passed++;
    step();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL split_drained got=%0b exp=0", bus.valid_o); else passed++;
  endtask

  // Back-to-back stream of XL forms and illegal words, one per cycle.
  task automatic test_back_to_back();
    logic [31:0] ins  [5] = '{32'h4C000420, 32'h7C000000, 32'h4E800020, 32'h4E800460, 32'h4E800421};
    logic [2:0]  kind [5] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd3};
    logic [4:0]  flg  [5] = '{5'b00000, 5'b00000, 5'b00100, 5'b00001, 5'b10010};
    logic        ill  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], 64'h3000 + 64'(i));
      step();
      checks++; if ({bus.valid_o, bus.illegal_o, bus.kind_o, bus.funcUnit_o} !== {1'b1, ill[i], kind[i], 3'd6})
        $display("FAIL b2b_%0d_kind got=%0b/%0b/%0d/%0d exp=1/%0b/%0d/6", i, bus.valid_o, bus.illegal_o, bus.kind_o, bus.funcUnit_o, ill[i], kind[i]); else passed++;
      checks++; if ({bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o, bus.offset_o} !== {flg[i], 64'd0})
        $display("FAIL b2b_%0d_flags got=%b/%0h exp=%b/0", i, {bus.ctrRd_o, bus.ctrWr_o, bus.lrRd_o, bus.lrWr_o, bus.tarRd_o}, bus.offset_o, flg[i]); else passed++;
    end
    bus.valid_i = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_addr [5] = '{64'h4000, 64'h4004, 64'h4008, 64'h400C, 64'h5000};
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h41820008, exp_addr[i]);
      step();
      if (i == 2) begin
        checks++; if (bus.ready_o !== 1'b1) $display("FAIL bp_ready_3 got=%0b exp=1", bus.ready_o); else passed++;
      end
    end
    drive(32'h41820008, 64'h5000);
    checks++; if (bus.ready_o !== 1'b0) $display("FAIL bp_ready_full got=%0b exp=0", bus.ready_o); else passed++;
    step();
    checks++; if ({bus.ready_o, bus.address_o} !== {1'b0, 64'h4000}) $display("FAIL bp_hold got=%0b/%0h exp=0/4000", bus.ready_o, bus.address_o); else passed++;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.valid_o, bus.address_o} !== {1'b1, exp_addr[i]}) $display("FAIL bp_order_%0d got=%0b/%0h exp=1/%0h", i, bus.valid_o, bus.address_o, exp_addr[i]); else passed++;
      if (i == 1) begin
        checks++; if (bus.ready_o !== 1'b1) $display("FAIL bp_ready_back got=%0b exp=1", bus.ready_o); else passed++;
      end
      step();
      if (i == 1) bus.valid_i = 1'b0;
    end
    checks++; if ({bus.valid_o, bus.ready_o} !== 2'b01) $display("FAIL bp_empty got=%b exp=01", {bus.valid_o, bus.ready_o}); else passed++;
  endtask

  task automatic test_reset_in_split();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h41820008, 64'h6000 + 64'(4 * i));
      step();
    end
    drive(32'h42000005, 64'h600C);
    step();
    bus.valid_i = 1'b0;
    checks++; if ({bus.ready_o, bus.valid_o, bus.address_o} !== {1'b0, 1'b1, 64'h6000}) $display("FAIL rs_full got=%0b/%0b/%0h exp=0/1/6000", bus.ready_o, bus.valid_o, bus.address_o); else passed++;
    rst_n = 1'b0;
    step();
    checks++; if ({bus.valid_o, bus.ready_o} !== 2'b00) $display("FAIL rs_held got=%b exp=00", {bus.valid_o, bus.ready_o}); else passed++;
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({bus.valid_o, bus.minId_o} !== {1'b0, 7'd0}) $display("FAIL rs_no_uop1_%0d got=%0b/%0d exp=0/0", i, bus.valid_o, bus.minId_o); else passed++;
    end
    checks++; if (bus.ready_o !== 1'b1) $display("FAIL rs_ready got=%0b exp=1", bus.ready_o); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_bc();
    test_b();
    test_split();
    test_back_to_back();
    test_backpressure();
    test_reset_in_split();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
